// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN image input path.
package bnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  // Binarized pixel values, sign-extended by the user to the stream width.
  localparam logic signed [PIX_W-1:0] BIN_POS = 32'sd1;
  localparam logic signed [PIX_W-1:0] BIN_NEG = -32'sd1;

endpackage

// File: rtl/bnn_skid_buf.sv
// Two-entry shifting register slice between the pixel RAM read port and the
// stream output. The head entry drives the output directly. There is no
// upstream ready: the RAM read cannot be stalled once issued, so the producer
// reserves space using the exported occupancy count before issuing a read.
module bnn_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   count
);

  localparam int DEPTH = 2;

  logic [W-1:0] entry_q [DEPTH];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic [1:0]   wpos;
  logic         pop;
  logic         push;

  assign m_valid = (count_reg != 2'd0);
  assign m_data  = entry_q[0];
  assign count   = count_reg;
  assign pop     = m_valid && m_ready;
  assign push    = s_valid;
  // Slot the incoming word lands in, after any shift caused by a pop.
  assign wpos    = count_reg - {1'b0, pop};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] ent_reg;
      logic [W-1:0] ent_next;

      if (gi < DEPTH - 1) begin : g_shift
        // Entry shifts toward the head on a pop, or captures the incoming word.
        always_comb begin
          ent_next = ent_reg;
          if (pop) ent_next = entry_q[gi+1];
          if (push && (wpos == 2'(gi))) ent_next = s_data;
        end
      end else begin : g_tail
        // Tail entry only ever captures the incoming word.
        always_comb begin
          ent_next = ent_reg;
          if (push && (wpos == 2'(gi))) ent_next = s_data;
        end
      end

      // Entry storage; cleared so the output data reads zero out of reset.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ent_reg <= '0;
        else       ent_reg <= ent_next;
      end

      assign entry_q[gi] = ent_reg;
    end
  endgenerate

  // Occupancy bookkeeping; the producer guarantees it never exceeds DEPTH.
  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_reg <= 2'd0;
    else       count_reg <= count_next;
  end

endmodule

// File: rtl/bnn_image_streamer.sv
// Frame buffer and valid/ready pixel source for the BNN accelerator.
// The host fills a 28x28 pixel RAM while idle, then pulses start; the frame is
// replayed in raster order with back-pressure from image_tready.
// Optional feature macro: BNN_IMG_BINARIZE_EN (outputs +1/-1 per pixel
// against BIN_THRESH instead of the stored word).
module bnn_image_streamer #(
  parameter int                        DATA_W     = bnn_pkg::PIX_W,
  parameter int                        NPIX       = bnn_pkg::NPIX,
  parameter int                        ADDR_W     = 10,
  parameter logic signed [DATA_W-1:0]  BIN_THRESH = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              image_tvalid,
  output logic [DATA_W-1:0] image_tdata,
  output logic              image_tlast,
  input  logic              image_tready
);

  import bnn_pkg::*;

  localparam logic [ADDR_W-1:0] NPIX_A    = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  logic [DATA_W-1:0] mem [0:NPIX-1];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pix_out;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W-1:0] beat_cnt_reg;
  logic [ADDR_W-1:0] beat_cnt_next;
  logic              rd_vld_reg;
  logic              rd_last_reg;
  logic              wr_err_reg;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ok;
  logic              pop;
  logic [2:0]        occ;
  logic              space;
  logic [1:0]        skid_cnt;
  logic              skid_last;

  assign wr_ok  = wr_en && (state_reg == IDLE) && (wr_addr < NPIX_A);
  assign pop    = image_tvalid && image_tready;
  // Words held plus the one in flight, after this cycle's pop.
  assign occ    = {1'b0, skid_cnt} + {2'b0, rd_vld_reg} - {2'b0, pop};
  assign space  = (occ < 3'd2);
  assign busy   = (state_reg == STREAM);
  assign done   = (state_reg == DONE);
  assign wr_err = wr_err_reg;
  // Both the read-side tag and the output beat count must agree on the end.
  assign image_tlast = image_tvalid && skid_last && (beat_cnt_reg == LAST_ADDR);

  // Next-state, read issue and beat counting. Pixel 0 is read in the start
  // cycle itself so the first beat is valid two cycles after start.
  always_comb begin
    state_next    = state_reg;
    rd_ptr_next   = rd_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    rd_en         = 1'b0;
    rd_addr       = rd_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = STREAM;
          rd_en         = 1'b1;
          rd_addr       = '0;
          rd_ptr_next   = ADDR_W'(1);
          beat_cnt_next = '0;
        end
      end
      STREAM: begin
        if ((rd_ptr_reg < NPIX_A) && space) begin
          rd_en       = 1'b1;
          rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end
        if (pop) begin
          if (beat_cnt_reg != LAST_ADDR) beat_cnt_next = beat_cnt_reg + ADDR_W'(1);
          if (image_tlast) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state; a reset aborts any stream in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      rd_vld_reg   <= 1'b0;
      rd_last_reg  <= 1'b0;
      wr_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      rd_vld_reg   <= rd_en;
      if (rd_en) rd_last_reg <= (rd_addr == LAST_ADDR);
      wr_err_reg   <= wr_en && !wr_ok;
    end
  end

  // Pixel RAM: one write port, one registered read port (read-old on collision).
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

`ifdef BNN_IMG_BINARIZE_EN
  // Signed threshold on the read word; the skid entry register captures it.
  assign pix_out = ($signed(ram_q) >= BIN_THRESH) ? DATA_W'(BIN_POS) : DATA_W'(BIN_NEG);
`else
  assign pix_out = ram_q;
`endif

  bnn_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (rd_vld_reg),
    .s_data  ({rd_last_reg, pix_out}),
    .m_valid (image_tvalid),
    .m_ready (image_tready),
    .m_data  ({skid_last, image_tdata}),
    .count   (skid_cnt)
  );

endmodule

// File: tb/tb_bnn_image_streamer.sv
// Directed bench for bnn_image_streamer: full-frame replay with continuous and
// toggling ready, write rejection, mid-frame reset, ignored restart, and
// (with BNN_IMG_BINARIZE_EN) binarized output.
module tb_bnn_image_streamer;

  localparam int NPIX = 784;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic        start;
  logic        busy;
  logic        done;
  logic        image_tvalid;
  logic [31:0] image_tdata;
  logic        image_tlast;
  logic        image_tready;

  int vectors     = 0;
  int miscompares = 0;
  int raw_mem [NPIX];

  bnn_image_streamer dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .image_tvalid (image_tvalid),
    .image_tdata  (image_tdata),
    .image_tlast  (image_tlast),
    .image_tready (image_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input int raw);
`ifdef BNN_IMG_BINARIZE_EN
    return (raw >= 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`else
    return 32'(raw);
`endif
  endfunction

  // One host write; exp_err is the hand-derived rejection outcome.
  task automatic write_pix(input int addr, input int data, input bit exp_err);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 10'(addr); wr_data = 32'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check($sformatf("wr_err@%0d", addr), 32'(wr_err), 32'(exp_err));
    if (!exp_err) raw_mem[addr] = data;
  endtask

  // Start a frame and consume it. ready_mode 0: always ready; 1: 1,0,0,1 pattern.
  // restart_at / abort_at / wr_at are beat indices (-1 disables).
  task automatic run_frame(input string tag, input int ready_mode, input int restart_at,
                           input int abort_at, input int wr_at);
    int beats = 0, first_v = -1, last_k = -10, wr_k = -10, done_cnt = 0;
    bit restarted = 0, held = 0, held_last = 0;
    logic [31:0] held_data = '0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      if (restart_at >= 0 && beats == restart_at && !restarted) begin
        start = 1'b1; restarted = 1;
      end
      wr_en = 1'b0;
      if (wr_at >= 0 && beats == wr_at && wr_k < 0) begin
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'h0BAD_0005; wr_k = k;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        rstn = 1'b0;
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          check({tag, "_rst_tvalid"}, 32'(image_tvalid), 32'd0);
          check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        $display("frame %s: reset after %0d beats", tag, beats);
        return;
      end
      image_tready = (ready_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      @(negedge clk);
      if (first_v < 0 && image_tvalid) first_v = k;
      if (k == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (k == wr_k + 1) check({tag, "_wr_err"}, 32'(wr_err), 32'd1);
      if (held) begin
        check({tag, "_hold_valid"}, 32'(image_tvalid), 32'd1);
        check({tag, "_hold_data"}, image_tdata, held_data);
        check({tag, "_hold_last"}, 32'(image_tlast), 32'(held_last));
      end
      if (image_tvalid && image_tready) begin
        check($sformatf("%s_data[%0d]", tag, beats), image_tdata, exp_val(raw_mem[beats]));
        check($sformatf("%s_last[%0d]", tag, beats), 32'(image_tlast), 32'(beats == NPIX - 1));
        beats++;
        if (beats == NPIX) last_k = k;
      end
      held      = image_tvalid && !image_tready;
      held_data = image_tdata;
      held_last = image_tlast;
      if (done) done_cnt++;
      if (beats == NPIX && k == last_k + 1) begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      if (beats == NPIX && k == last_k + 2) break;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_beats"}, 32'(beats), 32'(NPIX));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_first_valid_cycle"}, 32'(first_v), 32'd2);
    check({tag, "_idle_tvalid"}, 32'(image_tvalid), 32'd0);
    $display("frame %s: %0d beats, %0d done pulses", tag, beats, done_cnt);
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; image_tready = 1'b0;
    for (int i = 0; i < NPIX; i++) raw_mem[i] = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(image_tvalid), 32'd0);
    check("rst_tdata", image_tdata, 32'd0);
    check("rst_tlast", 32'(image_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Ramp frame 0..783.
    for (int i = 0; i < NPIX; i++) write_pix(i, i, 1'b0);
    $display("load: ramp 0..%0d written", NPIX - 1);

    run_frame("cont", 0, -1, -1, -1);
    run_frame("toggle", 1, -1, -1, 50);

    // Out-of-range write is rejected; the pulse lasts one cycle.
    write_pix(800, 32'h1234, 1'b1);
    @(negedge clk);
    check("wr_err_pulse_end", 32'(wr_err), 32'd0);
    $display("write: addr 800 rejected");

    run_frame("abort", 0, -1, 300, -1);
    run_frame("after_rst", 0, -1, -1, -1);
    run_frame("restart", 0, 100, -1, -1);

    // Signed pixels at the head of the frame.
    write_pix(0, -5, 1'b0);
    write_pix(1, 0, 1'b0);
    write_pix(2, 7, 1'b0);
    $display("load: pixels {-5,0,7} at 0..2");
    run_frame("signed", 0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
